// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
// Latency: none, this is wiring only.
// Backpressure: imem_ready low stretches a request for as many cycles as memory needs.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    // Fetch stage side: issues the request and address, consumes the word
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    // Memory side: answers the request
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word, presents it registered until commit.
// Latency: word visible the cycle after imem_ready; new fetch request the cycle after commit.
// Backpressure: FETCH waits on imem_ready indefinitely, HOLD waits on commit indefinitely.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic [31:0]  pc,
    output logic [31:0]  pc_plus4,
    input  logic         commit,
    input  logic         branch,
    input  logic         bne,
    input  logic         jump,
    input  logic         jump_reg,
    input  logic         zero,
    input  logic [31:0]  imm,
    input  logic [31:0]  reg_target
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state;
    logic        taken;
    logic [31:0] next_pc;

    // All outputs come from registered state only
    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;

    // beq and bne together simply OR their conditions
    assign taken = (branch & zero) | (bne & ~zero);

    // Next-PC selection: jr beats j beats taken branch beats fall-through
    always_comb begin
        next_pc = pc_plus4;
        if (jump_reg) begin
            next_pc = reg_target & 32'hFFFF_FFFC;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (taken) begin
            // Shift discards imm[31:30]; arithmetic wraps silently mod 2^32
            next_pc = pc_plus4 + (imm << 2);
        end
    end

    // Fetch/hold sequencing; reset drops any in-flight word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem.imem_ready) begin
                        instr       <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (commit) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit.
// Latency: checks capture one cycle after ready and the new fetch one cycle after commit.
// Backpressure: random memory wait states and random commit delays.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit = 1'b0;
    logic        branch = 1'b0;
    logic        bne = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] reg_target = 32'h0;

    fetch_unit_if f_if();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (f_if),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .commit      (commit),
        .branch      (branch),
        .bne         (bne),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .zero        (zero),
        .imm         (imm),
        .reg_target  (reg_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_pc = RESET_PC;
    logic        prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference next-PC, written from the architectural rules
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input logic br, input logic bn, input logic jp,
                                               input logic jr, input logic z,
                                               input logic [31:0] immv, input logic [31:0] rt);
        logic [31:0] p4;
        p4 = cur + 32'd4;
        if (jr)
            return rt & ~32'h3;
        if (jp)
            return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        if ((br && z) || (bn && !z))
            return p4 + immv * 32'd4;
        return p4;
    endfunction

    // Monitor: each newly presented instruction is matched against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_instr", {31'b0, instr_valid}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_pc", pc, e.pc);
                    chk("sb_instr", instr, e.word);
                    chk("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
                end
            end
            prev_valid = instr_valid;
        end
    end

    // Release reset at a falling edge: one IDLE cycle, then fetch from RESET_PC
    task automatic release_reset();
        rst = 1'b0;
        model_pc = RESET_PC;
        chk("idle_req", {31'b0, f_if.imem_req}, 32'h0);
        @(negedge clk);
        chk("first_req", {31'b0, f_if.imem_req}, 32'h1);
        chk("first_addr", f_if.imem_addr, RESET_PC);
    endtask

    task automatic do_instr(input int waits, input int hold, input logic [31:0] word,
                            input logic br, input logic bn, input logic jp, input logic jr,
                            input logic z, input logic [31:0] immv, input logic [31:0] rt,
                            input logic cif, input logic rst_in_hold);
        int n;
        exp_t e;
        n = 0;
        while (!f_if.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!f_if.imem_req) begin
            chk("req_timeout", {31'b0, f_if.imem_req}, 32'h1);
            return;
        end
        chk("fetch_addr", f_if.imem_addr, model_pc);
        // Wait states, optionally with a stray commit that must be ignored
        for (int w = 0; w < waits; w++) begin
            f_if.imem_ready = 1'b0;
            f_if.imem_rdata = $urandom;
            commit = cif;
            @(negedge clk);
            chk("wait_valid", {31'b0, instr_valid}, 32'h0);
            chk("wait_addr", f_if.imem_addr, model_pc);
            chk("wait_req", {31'b0, f_if.imem_req}, 32'h1);
        end
        commit = 1'b0;
        f_if.imem_ready = 1'b1;
        f_if.imem_rdata = word;
        e.pc = model_pc;
        e.word = word;
        exp_q.push_back(e);
        @(negedge clk);
        f_if.imem_ready = 1'b0;
        f_if.imem_rdata = $urandom;
        chk("hold_req", {31'b0, f_if.imem_req}, 32'h0);
        if (rst_in_hold) begin
            #2 rst = 1'b1;
            #1;
            chk("rst_valid", {31'b0, instr_valid}, 32'h0);
            chk("rst_pc", pc, RESET_PC);
            chk("rst_req", {31'b0, f_if.imem_req}, 32'h0);
            chk("rst_instr", instr, 32'h0);
            @(negedge clk);
            release_reset();
            return;
        end
        // HOLD: memory ready is ignored while waiting for commit
        for (int h = 0; h < hold; h++) begin
            f_if.imem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_valid", {31'b0, instr_valid}, 32'h1);
            chk("hold_pc", pc, model_pc);
        end
        f_if.imem_ready = 1'b0;
        branch = br;
        bne = bn;
        jump = jp;
        jump_reg = jr;
        zero = z;
        imm = immv;
        reg_target = rt;
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        model_pc = model_next(model_pc, word, br, bn, jp, jr, z, immv, rt);
        chk("commit_valid", {31'b0, instr_valid}, 32'h0);
        chk("commit_req", {31'b0, f_if.imem_req}, 32'h1);
        chk("commit_pc", f_if.imem_addr, model_pc);
    endtask

    task automatic seq(input int waits);
        do_instr(waits, 0, $urandom, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic jr_to(input logic [31:0] a);
        do_instr(0, 0, $urandom, 0, 0, 0, 1, 0, 32'h0, a, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] i16;
        f_if.imem_ready = 1'b0;
        f_if.imem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_req", {31'b0, f_if.imem_req}, 32'h0);
        chk("reset_addr", f_if.imem_addr, RESET_PC);
        chk("reset_pc_plus4", pc_plus4, RESET_PC + 32'd4);
        chk("reset_valid", {31'b0, instr_valid}, 32'h0);
        chk("reset_instr", instr, 32'h0);
        release_reset();

        // Sequential fetch 0,4,8,C then a 3-cycle wait at 0x10 with stray commits
        for (int k = 0; k < 4; k++) seq(0);
        do_instr(3, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0);

        // Branches at 0x20
        jr_to(32'h20);
        do_instr(0, 1, $urandom, 1, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0, 0, 0);
        chk("beq_taken", model_pc, 32'h1C);
        seq(0);
        do_instr(0, 0, $urandom, 1, 0, 0, 0, 0, 32'hFFFF_FFFE, 32'h0, 0, 0);
        chk("beq_not_taken", model_pc, 32'h24);
        jr_to(32'h20);
        do_instr(0, 0, $urandom, 0, 1, 0, 0, 0, 32'h3, 32'h0, 0, 0);

        // Jumps
        jr_to(32'h4000_0000);
        do_instr(0, 0, 32'h0800_0100, 0, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0);
        do_instr(0, 0, $urandom, 0, 0, 0, 1, 0, 32'h0, 32'h87, 0, 0);
        do_instr(0, 0, 32'h0800_0100, 1, 0, 1, 1, 1, 32'h5, 32'h1234_5678, 0, 0);

        // Wrap-around
        jr_to(32'hFFFF_FFFC);
        seq(1);

        // Reset while holding the word at 0x40
        jr_to(32'h40);
        do_instr(0, 0, $urandom, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1);

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            i16 = 16'($urandom);
            do_instr($urandom_range(0, 3), $urandom_range(0, 2), $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1)), {{16{i16[15]}}, i16}, $urandom,
                     1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
